// File: rtl/signed_divider.sv
// Sequential signed divider: restoring division, one quotient bit per clock.
// Truncating quotient, remainder follows the dividend sign.
module signed_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   r_q, r_d;
  logic             sq_q, sq_d;
  logic             sr_q, sr_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbzo_q, dbzo_d;
  logic             ovfo_q, ovfo_d;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   r_sh;
  logic             ge;

  // Most negative value maps to its unsigned magnitude unchanged.
  assign a_abs = InA[WIDTH-1] ? -InA : InA;
  assign b_abs = InB[WIDTH-1] ? -InB : InB;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbzo_d  = dbzo_q;
    ovfo_d  = ovfo_q;
    r_sh    = {r_q[WIDTH-1:0], a_q[WIDTH-1]};
    ge      = (r_sh >= {1'b0, b_q});
    unique case (state_q)
      IDLE: begin
        if (start) begin
          b_d   = b_abs;
          sq_d  = InA[WIDTH-1] ^ InB[WIDTH-1];
          sr_d  = InA[WIDTH-1];
          dbz_d = (InB == '0);
          ovf_d = (InA == MIN) && (InB == '1);
          cnt_d = CW'(WIDTH - 1);
          if (InB == '0) begin
            // Remainder carries the dividend straight through.
            a_d     = '0;
            r_d     = {1'b0, a_abs};
            state_d = FIX;
          end else begin
            a_d     = a_abs;
            r_d     = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        r_d = ge ? (r_sh - {1'b0, b_q}) : r_sh;
        a_d = {a_q[WIDTH-2:0], ge};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        quo_d   = sq_q ? -a_q : a_q;
        rem_d   = sr_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        dbzo_d  = dbz_q;
        ovfo_d  = ovf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbzo_q  <= 1'b0;
      ovfo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbzo_q  <= dbzo_d;
      ovfo_q  <= ovfo_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbzo_q;
  assign overflow    = ovfo_q;

endmodule

// File: tb/tb_signed_divider.sv
// Scoreboard bench for signed_divider: expected results queued at start,
// popped and compared on each done pulse.
module tb_signed_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] InA = '0;
  logic [7:0] InB = '0;
  logic       busy, done, div_by_zero, overflow;
  logic [7:0] quotient, remainder;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         lat;
  } exp_t;

  exp_t sb[$];

  signed_divider #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .InA(InA),
    .InB(InB),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int sa, sb_, qi, ri;
    sa  = int'($signed(a));
    sb_ = int'($signed(b));
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    e.lat = 9;
    if (sb_ == 0) begin
      e.q = 8'h00;
      e.r = a;
      e.dbz = 1'b1;
      e.lat = 1;
    end else if (sa == -128 && sb_ == -1) begin
      e.q = 8'h80;
      e.r = 8'h00;
      e.ovf = 1'b1;
    end else begin
      qi = sa / sb_;
      ri = sa % sb_;
      e.q = qi[7:0];
      e.r = ri[7:0];
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one start; returns right after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    InA = a;
    InB = b;
    start = 1'b1;
    sb.push_back(model(a, b));
    tick();
    start = 1'b0;
    InA = 8'hA5;
    InB = 8'h3C;
  endtask

  task automatic wait_done(input int limit, output int edges,
                           output int bcnt, output bit got);
    edges = 0;
    got = 1'b0;
    bcnt = busy ? 1 : 0;
    while (edges < limit) begin
      tick();
      edges++;
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 20'h0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b want all 0",
               busy, done, quotient, remainder, div_by_zero, overflow);
    end
  endtask

  task automatic test_table();
    logic [7:0] ta[8] = '{8'd100, 8'h9C, 8'd100, 8'h9C, 8'h80, 8'h80, 8'h00, 8'd9};
    logic [7:0] tb[8] = '{8'd7, 8'd7, 8'hF9, 8'hF9, 8'hFF, 8'h01, 8'hFB, 8'd2};
    exp_t e;
    int edges, bcnt;
    bit got;
    for (int i = 0; i < 8; i++) begin
      issue(ta[i], tb[i]);
      wait_done(20, edges, bcnt, got);
      e = sb.pop_front();
      checks++;
      if (!got || edges != e.lat || bcnt != e.lat) begin
        errors++;
        $display("FAIL table%0d timing: got done=%b edges=%0d busy=%0d want %0d",
                 i, got, edges, bcnt, e.lat);
      end
      checks++;
      if (quotient !== e.q || remainder !== e.r ||
          div_by_zero !== e.dbz || overflow !== e.ovf) begin
        errors++;
        $display("FAIL table%0d %h/%h: got q=%h r=%h dbz=%b ovf=%b want q=%h r=%h dbz=%b ovf=%b",
                 i, ta[i], tb[i], quotient, remainder, div_by_zero, overflow,
                 e.q, e.r, e.dbz, e.ovf);
      end
    end
  endtask

  task automatic test_dbz();
    exp_t e;
    int edges, bcnt;
    bit got;
    issue(8'd5, 8'd0);
    wait_done(20, edges, bcnt, got);
    e = sb.pop_front();
    checks++;
    if (!got || edges != 1 || quotient !== e.q || remainder !== e.r ||
        div_by_zero !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL dbz: got done=%b edges=%0d q=%h r=%h dbz=%b ovf=%b want 1 edge q=%h r=%h dbz=1",
               got, edges, quotient, remainder, div_by_zero, overflow, e.q, e.r);
    end
    tick();
    checks++;
    if (done !== 1'b0 || div_by_zero !== 1'b1 || remainder !== 8'd5) begin
      errors++;
      $display("FAIL dbz_hold: got done=%b dbz=%b r=%h want 0 1 05",
               done, div_by_zero, remainder);
    end
    issue(8'd9, 8'd2);
    wait_done(20, edges, bcnt, got);
    e = sb.pop_front();
    checks++;
    if (!got || div_by_zero !== 1'b0 || quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL dbz_clear: got done=%b dbz=%b q=%h r=%h want dbz=0 q=%h r=%h",
               got, div_by_zero, quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int edges, bcnt;
    bit got;
    issue(8'd100, 8'd7);
    tick();
    tick();
    InA = 8'd50;
    InB = 8'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(20, edges, bcnt, got);
    e = sb.pop_front();
    checks++;
    if (!got || edges != 6 || quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL ignore_start: got done=%b edges=%0d q=%h r=%h want 6 q=%h r=%h",
               got, edges, quotient, remainder, e.q, e.r);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle: got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int edges, bcnt;
    bit got;
    issue(8'd100, 8'd7);
    wait_done(20, edges, bcnt, got);
    e = sb.pop_front();
    checks++;
    if (!got || quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL b2b_first: got done=%b q=%h r=%h want q=%h r=%h",
               got, quotient, remainder, e.q, e.r);
    end
    issue(8'd50, 8'd5);
    checks++;
    if (busy !== 1'b1 || quotient !== e.q) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b q=%h want busy=1 q=%h held",
               busy, quotient, e.q);
    end
    wait_done(20, edges, bcnt, got);
    e = sb.pop_front();
    checks++;
    if (!got || edges != 9 || quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL b2b_second: got done=%b edges=%0d q=%h r=%h want 9 q=%h r=%h",
               got, edges, quotient, remainder, e.q, e.r);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int edges, bcnt;
    bit got;
    issue(8'd100, 8'd7);
    e = sb.pop_front();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero, overflow} !== 20'h0) begin
      errors++;
      $display("FAIL abort_reset: got busy=%b done=%b q=%h r=%h dbz=%b ovf=%b want all 0",
               busy, done, quotient, remainder, div_by_zero, overflow);
    end
    wait_done(12, edges, bcnt, got);
    checks++;
    if (got || bcnt != 0) begin
      errors++;
      $display("FAIL abort_nodone: got done=%b busy_cycles=%0d want 0 0", got, bcnt);
    end
    issue(8'd9, 8'd2);
    wait_done(20, edges, bcnt, got);
    e = sb.pop_front();
    checks++;
    if (!got || edges != 9 || quotient !== 8'd4 || remainder !== 8'd1 ||
        quotient !== e.q || remainder !== e.r) begin
      errors++;
      $display("FAIL abort_restart: got done=%b edges=%0d q=%h r=%h want 9 q=04 r=01",
               got, edges, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_table();
    test_dbz();
    test_ignore_start();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
